// File: rtl/jstk_pkg.sv
// Shared types, packet field offsets, FSM states and pulse-mapping helpers
// for the joystick-driven servo block.
package jstk_pkg;

  typedef logic [9:0]  pos_t;
  typedef logic [11:0] us_t;

  // Bit offsets of the fields inside the 40-bit packet
  localparam int X_LO_BIT = 32;
  localparam int X_HI_BIT = 24;
  localparam int Y_LO_BIT = 16;
  localparam int Y_HI_BIT = 8;
  localparam int BTN_BIT  = 0;

  localparam int POS_CENTER = 512;

  typedef enum logic [1:0] {RUN, SAMPLE, SLEW} state_t;

  function automatic us_t pos_to_us(pos_t p, int pmin, int pmax);
    us_t sum;
    sum = us_t'(pmin) + us_t'(p);
    return (sum > us_t'(pmax)) ? us_t'(pmax) : sum;
  endfunction

  function automatic pos_t apply_deadband(pos_t p, int db);
    int d;
    d = int'(p) - POS_CENTER;
    if (d < 0) d = -d;
    return (d <= db) ? pos_t'(POS_CENTER) : p;
  endfunction

endpackage

// File: rtl/jstk_servo_drive_pwm_ch.sv
// One servo channel: current pulse width, per-frame slew limiting and the
// registered PWM compare against the shared microsecond counter.
module servo_pwm_ch
  import jstk_pkg::*;
#(
  parameter int UW        = 15,
  parameter int PULSE_RST = 1512,
  parameter int SLEW_STEP = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  us_t           target,
  input  logic          slew,
  input  logic [UW-1:0] us_cnt,
  output logic          pwm
);

  localparam us_t STEP = us_t'(SLEW_STEP);

  us_t  cur_q, cur_d;
  logic pwm_q, pwm_d;

  always_comb begin
    cur_d = cur_q;
    if (slew) begin
      if (target >= cur_q) begin
        cur_d = ((target - cur_q) <= STEP) ? target : cur_q + STEP;
      end else begin
        cur_d = ((cur_q - target) <= STEP) ? target : cur_q - STEP;
      end
    end
    pwm_d = 32'(us_cnt) < 32'(cur_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= us_t'(PULSE_RST);
      pwm_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/jstk_servo_drive.sv
// Joystick packet to dual 50 Hz servo PWM: timebase, sample/slew FSM, fields.
// Optional centre deadband is enabled by defining JSTK_DEADBAND_EN.
module jstk_servo_drive #(
  parameter int US_DIV       = 100,
  parameter int PERIOD_US    = 20000,
  parameter int PULSE_MIN_US = 1000,
  parameter int PULSE_MAX_US = 2000,
  parameter int SLEW_STEP_US = 50,
  parameter int DEADBAND     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] din,
  output logic        pwm_x,
  output logic        pwm_y,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic [2:0]  btn,
  output logic        frame_tick
);
  import jstk_pkg::*;

  localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int UW = $clog2(PERIOD_US);

  logic [PW-1:0] presc_q, presc_d;
  logic [UW-1:0] us_q, us_d;
  logic          preroll_q, preroll_d;
  logic          tick_q, tick_d;
  state_t        state_q, state_d;
  pos_t          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [2:0]    btn_q, btn_d;
  pos_t          x_raw, y_raw, x_sel, y_sel;
  us_t           tgt_x, tgt_y;
  logic          sample, slew;
  logic          unused_bits;

  assign x_raw = {din[X_HI_BIT+1:X_HI_BIT], din[X_LO_BIT+7:X_LO_BIT]};
  assign y_raw = {din[Y_HI_BIT+1:Y_HI_BIT], din[Y_LO_BIT+7:Y_LO_BIT]};
  assign unused_bits = ^{din[31:26], din[15:10], din[7:3], 32'(DEADBAND)};

`ifdef JSTK_DEADBAND_EN
  assign x_sel = apply_deadband(x_raw, DEADBAND);
  assign y_sel = apply_deadband(y_raw, DEADBAND);
`else
  assign x_sel = x_raw;
  assign y_sel = y_raw;
`endif

  // The microsecond just after reset is a pre-roll: us_cnt holds at 0 through
  // the first prescaler wrap so the first frame starts US_DIV cycles later.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    us_d      = us_q;
    preroll_d = preroll_q;
    if (presc_q == PW'(US_DIV - 1)) begin
      presc_d   = '0;
      preroll_d = 1'b0;
      if (!preroll_q) begin
        us_d = (us_q == UW'(PERIOD_US - 1)) ? '0 : us_q + 1'b1;
      end
    end
    tick_d = (presc_d == '0) && (us_d == '0);
  end

  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    slew    = 1'b0;
    case (state_q)
      RUN:     if (tick_q) state_d = SAMPLE;
      SAMPLE: begin
        sample  = 1'b1;
        state_d = SLEW;
      end
      SLEW: begin
        slew    = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    pos_x_d = sample ? x_sel : pos_x_q;
    pos_y_d = sample ? y_sel : pos_y_q;
    btn_d   = sample ? din[BTN_BIT+2:BTN_BIT] : btn_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      us_q      <= '0;
      preroll_q <= 1'b1;
      tick_q    <= 1'b0;
      state_q   <= RUN;
      pos_x_q   <= pos_t'(POS_CENTER);
      pos_y_q   <= pos_t'(POS_CENTER);
      btn_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      us_q      <= us_d;
      preroll_q <= preroll_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      btn_q     <= btn_d;
    end
  end

  // Targets follow the latched positions, so they are stable during SLEW
  assign tgt_x = pos_to_us(pos_x_q, PULSE_MIN_US, PULSE_MAX_US);
  assign tgt_y = pos_to_us(pos_y_q, PULSE_MIN_US, PULSE_MAX_US);

  servo_pwm_ch #(
    .UW        (UW),
    .PULSE_RST (PULSE_MIN_US + POS_CENTER),
    .SLEW_STEP (SLEW_STEP_US)
  ) u_ch_x (
    .clk    (clk),
    .rst    (rst),
    .target (tgt_x),
    .slew   (slew),
    .us_cnt (us_q),
    .pwm    (pwm_x)
  );

  servo_pwm_ch #(
    .UW        (UW),
    .PULSE_RST (PULSE_MIN_US + POS_CENTER),
    .SLEW_STEP (SLEW_STEP_US)
  ) u_ch_y (
    .clk    (clk),
    .rst    (rst),
    .target (tgt_y),
    .slew   (slew),
    .us_cnt (us_q),
    .pwm    (pwm_y)
  );

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign btn        = btn_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_jstk_servo_drive.sv
// Directed bench for jstk_servo_drive with a shortened frame; pulse widths
// are measured in clock cycles and compared against hand-computed values.
module tb_jstk_servo_drive;

  localparam int US_DIV = 4;
  localparam int PERIOD = 1100;
  localparam int PMIN   = 100;
  localparam int PMAX   = 1000;
  localparam int STEP   = 200;
  localparam int DB     = 32;
  localparam int FRAME  = US_DIV * PERIOD;

  localparam logic [39:0] DIN_CTR = 40'h00_02_00_02_00;  // X=512 Y=512
  localparam logic [39:0] DIN_MAX = 40'hFF_03_00_02_00;  // X=1023 Y=512
  localparam logic [39:0] DIN_ZRO = 40'h00_00_00_02_00;  // X=0 Y=512
  localparam logic [39:0] DIN_530 = 40'h12_02_00_02_05;  // X=530 Y=512 btn=5

  logic        clk, rst;
  logic [39:0] din;
  logic        pwm_x, pwm_y, frame_tick;
  logic [9:0]  pos_x, pos_y;
  logic [2:0]  btn;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int n;

  jstk_servo_drive #(
    .US_DIV       (US_DIV),
    .PERIOD_US    (PERIOD),
    .PULSE_MIN_US (PMIN),
    .PULSE_MAX_US (PMAX),
    .SLEW_STEP_US (STEP),
    .DEADBAND     (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .pwm_x      (pwm_x),
    .pwm_y      (pwm_y),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .btn        (btn),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Counts negedges until frame_tick is seen, bounded to just over a frame
  task automatic wait_tick(output int cnt);
    cnt = 0;
    while (frame_tick !== 1'b1 && cnt < FRAME + 16) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Starts on a frame_tick negedge, counts high cycles for one frame and ends
  // on the next frame_tick negedge; optionally swaps din part-way through.
  task automatic frame(input string tag, input int ex_us, input int ey_us,
                       input int chg_at, input logic [39:0] chg_din);
    int hx, hy;
    hx = 0;
    hy = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == chg_at) din = chg_din;
      @(negedge clk);
      hx += int'(pwm_x);
      hy += int'(pwm_y);
    end
    $display("frame %s: x_cycles=%0d y_cycles=%0d pos_x=%0d pos_y=%0d btn=%0d",
             tag, hx, hy, pos_x, pos_y, btn);
    check({tag, "_wx"}, hx, ex_us * US_DIV);
    check({tag, "_wy"}, hy, ey_us * US_DIV);
    check({tag, "_period"}, int'(frame_tick), 1);
  endtask

  initial begin
    rst = 1'b1;
    din = DIN_CTR;
    repeat (3) @(negedge clk);
    check("rst_pos_x", int'(pos_x), 512);
    check("rst_pos_y", int'(pos_y), 512);
    check("rst_btn", int'(btn), 0);
    check("rst_pwm_x", int'(pwm_x), 0);
    check("rst_pwm_y", int'(pwm_y), 0);
    check("rst_tick", int'(frame_tick), 0);
    rst = 1'b0;
    wait_tick(n);
    check("first_tick_delay", n, US_DIV);

    // Centre position holds the reset width
    frame("centre", 612, 612, -1, DIN_CTR);
    check("centre_pos_x", int'(pos_x), 512);

    // Full-scale X slews up and clamps at the maximum; Y untouched
    din = DIN_MAX;
    frame("max1", 812, 612, -1, DIN_MAX);
    check("max_pos_x", int'(pos_x), 1023);
    frame("max2", 1000, 612, -1, DIN_MAX);
    frame("max3", 1000, 612, -1, DIN_MAX);

    // Reset in the middle of a 1000 us pulse
    repeat (800 * US_DIV) @(negedge clk);
    check("pre_rst_pwm_x", int'(pwm_x), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_pwm_x", int'(pwm_x), 0);
    check("mid_rst_pwm_y", int'(pwm_y), 0);
    check("mid_rst_tick", int'(frame_tick), 0);
    @(negedge clk);
    check("mid_rst_pos_x", int'(pos_x), 512);
    rst = 1'b0;
    wait_tick(n);
    check("rst_tick_delay", n, US_DIV);
    frame("after_rst", 812, 612, -1, DIN_MAX);

    // X to zero slews down and settles at the minimum
    din = DIN_ZRO;
    frame("zero1", 612, 612, -1, DIN_ZRO);
    check("zero_pos_x", int'(pos_x), 0);
    frame("zero2", 412, 612, -1, DIN_ZRO);
    frame("zero3", 212, 612, -1, DIN_ZRO);
    frame("zero4", 100, 612, -1, DIN_ZRO);
    frame("zero5", 100, 612, -1, DIN_ZRO);

    // din changes mid-frame (us 50); nothing moves until the next sample
    frame("midchg", 100, 612, 50 * US_DIV, DIN_530);
    check("midchg_pos_x", int'(pos_x), 0);
    check("midchg_btn", int'(btn), 0);
    frame("postchg", 300, 612, -1, DIN_530);
    check("postchg_pos_x", int'(pos_x), 530);
    check("postchg_btn", int'(btn), 5);

    // X=530 from reset: deadband either snaps it to centre or passes it raw
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_tick(n);
    check("db_tick_delay", n, US_DIV);
`ifdef JSTK_DEADBAND_EN
    frame("x530", 612, 612, -1, DIN_530);
    check("x530_pos_x", int'(pos_x), 512);
`else
    frame("x530", 630, 612, -1, DIN_530);
    check("x530_pos_x", int'(pos_x), 530);
`endif
    check("x530_btn", int'(btn), 5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/jstk_servo_drive.md
Name: jstk_servo_drive

Overview:
- Downstream consumer of the 40-bit joystick packet held by the SPI receive controller (5 bytes, first byte received in bits [39:32]).
- Extracts 10-bit X/Y positions and the button bits, and maps each position to a servo pulse width in microseconds.
- Applies a per-frame slew limit and generates two 50 Hz servo PWM outputs for the Basys3 servo header.

Parameters:
- US_DIV, 100, clock cycles per 1 us tick (100 MHz clk); must be >= 4.
- PERIOD_US, 20000, PWM frame length in us.
- PULSE_MIN_US, 1000, pulse width for position 0.
- PULSE_MAX_US, 2000, upper clamp on pulse width.
- SLEW_STEP_US, 50, maximum change in pulse width per frame.
- DEADBAND, 32, half-width of the centre deadband in position LSBs (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  40  joystick packet from the SPI controller, held stable between packets.
- pwm_x  out  1  servo X PWM.
- pwm_y  out  1  servo Y PWM.
- pos_x  out  10  X position latched this frame.
- pos_y  out  10  Y position latched this frame.
- btn  out  3  button bits latched this frame.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Field extraction:
  - X = {din[25:24], din[39:32]}
  - Y = {din[9:8], din[23:16]}
  - btn = din[2:0]
- Timebase:
  - presc counts 0..US_DIV-1.
  - us_cnt advances by 1 when presc wraps and counts 0..PERIOD_US-1, then wraps to 0.
  - frame_tick is high for exactly the one cycle where presc==0 and us_cnt==0.
- FSM states: RUN, SAMPLE, SLEW.
  - RUN -> SAMPLE on the cycle frame_tick is high.
  - SAMPLE (1 cycle): latch din fields into pos_x, pos_y, btn. Compute target = min(PULSE_MIN_US + pos, PULSE_MAX_US) in 12-bit unsigned arithmetic. Go to SLEW.
  - SLEW (1 cycle): for each channel, if |target - cur| <= SLEW_STEP_US then cur = target, otherwise cur moves SLEW_STEP_US toward target. Go to RUN.
- PWM output:
  - pwm_* = (us_cnt < cur_*), registered (1-cycle latency from us_cnt).
  - cur changes only while us_cnt==0, so the pulse is already high and no glitch or runt pulse can occur.
- Packet updates: din changing mid-frame has no effect until the next SAMPLE. Stale din repeats the same target (idempotent).
- Reset, from any state including mid-frame:
  - presc=0, us_cnt=0, state=RUN
  - cur_x = cur_y = PULSE_MIN_US+512 = 1512
  - pos_x = pos_y = 512, btn=0
  - pwm_x = pwm_y = 0, frame_tick=0
  - The first frame_tick occurs when presc first wraps back to 0 after reset.
- Boundaries:
  - pos=1023 clamps to 2000.
  - pos=0 gives 1000.
  - target==cur means no change.
  - Simultaneous X/Y updates are independent.

Optional Feature:
- Macro: JSTK_DEADBAND_EN.
- Defined: in SAMPLE, any position with |pos-512| <= DEADBAND is replaced by 512 before target computation. pos_x/pos_y report the substituted value.
- Undefined: positions are used raw and the DEADBAND parameter is ignored.

Decomposition:
- Package jstk_pkg:
  - typedef pos_t (logic [9:0]) and us_t (logic [11:0])
  - bit-offset constants for the X/Y/button fields
  - POS_CENTER=512
  - FSM state enum
- Sub-module servo_pwm_ch, instantiated twice: holds cur, the slew logic and the compare register. Inputs: target, slew strobe, us_cnt. Output: pwm bit.
- The top level owns the timebase, FSM and field extraction.

Test Plan:
- Reset, then hold din=0x0002_0002_00 (X=Y=512) -> pwm_x/pwm_y high for 1512 us of every 20000 us; pos_x=512.
- X=1023 (din[39:32]=FF, din[25:24]=3) from reset -> X widths 1562, 1612, ... ; 2000 reached on the 10th frame, then stable. Y remains 1512.
- From 2000, step X to 0 -> widths decrease by 50 per frame down to 1000, then stay at 1000.
- X=530 with JSTK_DEADBAND_EN -> width 1512 and pos_x=512. Without the macro -> width 1530 and pos_x=530.
- Assert rst mid-pulse at us_cnt=800 -> pwm low on the following cycle, cur=1512, and the next frame_tick occurs US_DIV cycles after rst deasserts.
- Change din mid-frame (us_cnt=5000) -> no change in width, pos or btn until the next frame_tick+1. din[2:0]=3'b101 then appears on btn.
